cpx_mac: RTL and testbench
==========================

// Module: cpx_mac
// PURPOSE
// - Pipelined complex multiply-accumulate. It is the parametrised successor of cpx_multiply.
// - Per sample pair it computes x*y, or x*conj(y) when conj_en=1.
// - It sums acc_len consecutive products at full precision and emits one result per block.
// - Sits in the CAF correlation path between the reference/shifted-signal sources and the peak search.
// - acc_len=1 gives a plain pipelined complex multiplier with backpressure.
// PARAMETERS
// - X_BITS       12  signed width of xi, xq
// - Y_BITS       12  signed width of yi, yq
// - MAX_ACC_LEN  16  largest accumulation length supported
// - CNT_BITS     $clog2(MAX_ACC_LEN+1)                   width of acc_len
// - OUT_BITS     X_BITS+Y_BITS+1+$clog2(MAX_ACC_LEN)     accumulator/output width (29 by default)
// PORTS
// - clk              in   1         single clock; all logic on rising edge
// - rst_n            in   1         asynchronous, active-low reset
// - m_axis_x_tvalid  in   1         x sample valid
// - m_axis_x_tready  out  1         x sample accepted
// - xi, xq           in   X_BITS    signed x sample
// - m_axis_y_tvalid  in   1         y sample valid
// - m_axis_y_tready  out  1         y sample accepted
// - yi, yq           in   Y_BITS    signed y sample
// - conj_en          in   1         1: x*conj(y); sampled with each pair
// - acc_len          in   CNT_BITS  block length, 1..MAX_ACC_LEN; 0 is treated as 1
// - s_axis_tvalid    out  1         result valid
// - s_axis_tready    in   1         downstream ready
// - i_out, q_out     out  OUT_BITS  signed accumulated result
// BEHAVIOUR
// - en = !(s_axis_tvalid & !s_axis_tready).
// - m_axis_x_tready = en & m_axis_y_tvalid. m_axis_y_tready = en & m_axis_x_tvalid.
// - A pair is consumed only when both valids are high and en=1. A lone x or y is never consumed.
// - Pipeline stages advance only while en=1. Each stage carries a valid bit; bubbles propagate as invalid.
// - S1: register xi, xq, yi, yq and conj_en.
// - S2: four signed products, each X_BITS+Y_BITS wide.
// - S3: form the sums at X_BITS+Y_BITS+1 bits.
// -     Normal: I = xi*yi - xq*yq, Q = xi*yq + xq*yi.
// -     Conj:   I = xi*yi + xq*yq, Q = xq*yi - xi*yq.
// - S4: sign-extend to OUT_BITS and accumulate.
// -     On the first product of a block: acc <= product (no bubble between blocks).
// -     Otherwise: acc <= acc + product. No rounding, saturation or overflow is possible.
// - Block length: acc_len is latched when the first product of a block enters S4. Changes mid-block are ignored.
// - Counter cnt runs 0..len-1. On the product where cnt==len-1, the output register loads acc+product,
//   s_axis_tvalid is set and cnt returns to 0.
// - Latency: 4 clk from acceptance of the last pair of a block to s_axis_tvalid (no stall).
// - Throughput: 1 pair per clk.
// - Output hold: while s_axis_tvalid=1 and s_axis_tready=0, i_out and q_out are stable and the pipeline is frozen.
// - s_axis_tvalid clears on a handshake, unless a new result loads in the same cycle.
// - Reset (async assert): all stage valids, acc, cnt, i_out, q_out and s_axis_tvalid go to 0; both trreadys go to 0.
//   A partial block is discarded. After deassertion the next accepted pair starts a new block.
// STRUCTURE
// - Shared package caf_pkg holds the CPX_MODE_NORMAL/CPX_MODE_CONJ constants and the clog2 helper
//   used for CNT_BITS and OUT_BITS.
// - Sub-module cpx_mult_pipe implements S1-S3 with an en input and a valid pipe.
// - cpx_mac adds the handshake, the S4 accumulator, the counter and the output register.
// TESTING
// - acc_len=1, conj_en=0, x=(3,4), y=(1,-2)
//   -> i_out=11, q_out=-2, s_axis_tvalid exactly 4 clk after the accept.
// - Same pair with conj_en=1 -> i_out=-5, q_out=10.
// - acc_len=4, conj_en=1, x=y=(100,-50) four times
//   -> a single output i_out=50000, q_out=0; no tvalid on the first 3 pairs.
// - acc_len=16, conj_en=0, all inputs -2048 for 16 pairs
//   -> i_out=0, q_out=134217728 (2^27), exact with no wrap.
// - Backpressure: hold s_axis_tready=0 while a result is pending and stream random pairs
//   -> both trready fall the same cycle, i_out and q_out are held, and no pair is lost or duplicated
//   versus the reference model.
// - Only x valid for 5 clk -> m_axis_x_tready=0 and nothing consumed.
//   Then acc_len=4 and rst_n pulsed low after 2 pairs
//   -> s_axis_tvalid=0 at once, and the next 4 pairs produce a fresh sum.

Source files
------------

// File: rtl/caf_pkg.sv
// Shared definitions for the CAF correlation path: complex-multiply modes and
// an elaboration-time ceil(log2) helper used to size counters and accumulators.
package caf_pkg;

    typedef enum logic {
        CPX_MODE_NORMAL = 1'b0,  // x * y
        CPX_MODE_CONJ   = 1'b1   // x * conj(y)
    } cpx_mode_e;

    // Smallest n with 2**n >= value (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cpx_mult_pipe.sv
// Three-stage complex multiplier: S1 input register, S2 four partial products,
// S3 I/Q sums one bit wider than the products. All stages advance on en_i and
// carry a valid bit so bubbles travel through as invalid slots.
module cpx_mult_pipe
    import caf_pkg::*;
#(
    parameter int unsigned X_BITS = 12,
    parameter int unsigned Y_BITS = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en_i,
    input  logic                            valid_i,
    input  logic signed [X_BITS-1:0]        xi_i,
    input  logic signed [X_BITS-1:0]        xq_i,
    input  logic signed [Y_BITS-1:0]        yi_i,
    input  logic signed [Y_BITS-1:0]        yq_i,
    input  logic                            conj_i,
    output logic                            valid_o,
    output logic signed [X_BITS+Y_BITS:0]   i_o,
    output logic signed [X_BITS+Y_BITS:0]   q_o
);

    localparam int unsigned P_BITS = X_BITS + Y_BITS;
    localparam int unsigned S_BITS = P_BITS + 1;

    // S1
    logic                     s1_v_q;
    logic signed [X_BITS-1:0] xi_q, xq_q;
    logic signed [Y_BITS-1:0] yi_q, yq_q;
    cpx_mode_e                s1_mode_q;

    // S2
    logic                     s2_v_q;
    logic signed [P_BITS-1:0] pii_q, pqq_q, piq_q, pqi_q;
    cpx_mode_e                s2_mode_q;

    // S3
    logic                     s3_v_q;
    logic signed [S_BITS-1:0] s3_i_q, s3_q_q;

    // Operands widened to product width so the multiplies are full precision
    logic signed [P_BITS-1:0] xi_e, xq_e, yi_e, yq_e;
    logic signed [S_BITS-1:0] sum_i_d, sum_q_d;

    // Sign-extend S1 operands to the product width
    always_comb begin
        xi_e = P_BITS'(xi_q);
        xq_e = P_BITS'(xq_q);
        yi_e = P_BITS'(yi_q);
        yq_e = P_BITS'(yq_q);
    end

    // Combine partial products; conjugation flips the sign of the yq terms
    always_comb begin
        sum_i_d = '0;
        sum_q_d = '0;
        case (s2_mode_q)
            CPX_MODE_CONJ: begin
                sum_i_d = S_BITS'(pii_q) + S_BITS'(pqq_q);
                sum_q_d = S_BITS'(pqi_q) - S_BITS'(piq_q);
            end
            default: begin
                sum_i_d = S_BITS'(pii_q) - S_BITS'(pqq_q);
                sum_q_d = S_BITS'(piq_q) + S_BITS'(pqi_q);
            end
        endcase
    end

    // S1..S3 registers, all gated by the shared pipeline enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            xi_q      <= '0;
            xq_q      <= '0;
            yi_q      <= '0;
            yq_q      <= '0;
            s1_mode_q <= CPX_MODE_NORMAL;
            s2_v_q    <= 1'b0;
            pii_q     <= '0;
            pqq_q     <= '0;
            piq_q     <= '0;
            pqi_q     <= '0;
            s2_mode_q <= CPX_MODE_NORMAL;
            s3_v_q    <= 1'b0;
            s3_i_q    <= '0;
            s3_q_q    <= '0;
        end else if (en_i) begin
            s1_v_q    <= valid_i;
            xi_q      <= xi_i;
            xq_q      <= xq_i;
            yi_q      <= yi_i;
            yq_q      <= yq_i;
            s1_mode_q <= conj_i ? CPX_MODE_CONJ : CPX_MODE_NORMAL;

            s2_v_q    <= s1_v_q;
            pii_q     <= xi_e * yi_e;
            pqq_q     <= xq_e * yq_e;
            piq_q     <= xi_e * yq_e;
            pqi_q     <= xq_e * yi_e;
            s2_mode_q <= s1_mode_q;

            s3_v_q    <= s2_v_q;
            s3_i_q    <= sum_i_d;
            s3_q_q    <= sum_q_d;
        end
    end

    // Stage-3 results drive the outputs directly
    always_comb begin
        valid_o = s3_v_q;
        i_o     = s3_i_q;
        q_o     = s3_q_q;
    end

endmodule

// File: rtl/cpx_mac.sv
// Pipelined complex multiply-accumulate: pairs x/y samples under a joint
// handshake, multiplies (optionally conjugating y), sums acc_len products at
// full precision and presents one result per block with backpressure.
module cpx_mac
    import caf_pkg::*;
#(
    parameter int unsigned X_BITS      = 12,
    parameter int unsigned Y_BITS      = 12,
    parameter int unsigned MAX_ACC_LEN = 16,
    parameter int unsigned CNT_BITS    = clog2(MAX_ACC_LEN + 1),
    parameter int unsigned OUT_BITS    = X_BITS + Y_BITS + 1 + clog2(MAX_ACC_LEN)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_axis_x_tvalid,
    output logic                       m_axis_x_tready,
    input  logic signed [X_BITS-1:0]   xi,
    input  logic signed [X_BITS-1:0]   xq,
    input  logic                       m_axis_y_tvalid,
    output logic                       m_axis_y_tready,
    input  logic signed [Y_BITS-1:0]   yi,
    input  logic signed [Y_BITS-1:0]   yq,
    input  logic                       conj_en,
    input  logic [CNT_BITS-1:0]        acc_len,
    output logic                       s_axis_tvalid,
    input  logic                       s_axis_tready,
    output logic signed [OUT_BITS-1:0] i_out,
    output logic signed [OUT_BITS-1:0] q_out
);

    localparam int unsigned S_BITS = X_BITS + Y_BITS + 1;

    logic                       run_q;
    logic                       en;
    logic                       accept;

    logic                       mp_valid;
    logic signed [S_BITS-1:0]   mp_i, mp_q;

    logic signed [OUT_BITS-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [OUT_BITS-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
    logic [CNT_BITS-1:0]        cnt_q, cnt_d, len_q, len_d;
    logic                       s_valid_q, s_valid_d;

    logic                       first;
    logic                       last;
    logic [CNT_BITS-1:0]        len_sel;
    logic signed [OUT_BITS-1:0] prod_i, prod_q, sum_i, sum_q;

    // Hold both input readies low through reset and for the first clock after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Global pipeline enable and the joint x/y handshake
    always_comb begin
        en              = !(s_valid_q && !s_axis_tready);
        m_axis_x_tready = en && run_q && m_axis_y_tvalid;
        m_axis_y_tready = en && run_q && m_axis_x_tvalid;
        accept          = en && run_q && m_axis_x_tvalid && m_axis_y_tvalid;
    end

    cpx_mult_pipe #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en),
        .valid_i (accept),
        .xi_i    (xi),
        .xq_i    (xq),
        .yi_i    (yi),
        .yq_i    (yq),
        .conj_i  (conj_en),
        .valid_o (mp_valid),
        .i_o     (mp_i),
        .q_o     (mp_q)
    );

    // S4: accumulate; the block's first product replaces acc and latches the
    // length, so back-to-back blocks need no idle slot between them
    always_comb begin
        first = (cnt_q == '0);
        if (!first) begin
            len_sel = len_q;
        end else if (acc_len == '0) begin
            len_sel = CNT_BITS'(1);
        end else begin
            len_sel = acc_len;
        end
        prod_i = OUT_BITS'(mp_i);
        prod_q = OUT_BITS'(mp_q);
        sum_i  = first ? prod_i : acc_i_q + prod_i;
        sum_q  = first ? prod_q : acc_q_q + prod_q;
        last   = (cnt_q == len_sel - CNT_BITS'(1));

        acc_i_d   = acc_i_q;
        acc_q_d   = acc_q_q;
        out_i_d   = out_i_q;
        out_q_d   = out_q_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        s_valid_d = s_valid_q && !s_axis_tready;

        if (en && mp_valid) begin
            len_d = len_sel;
            if (last) begin
                out_i_d   = sum_i;
                out_q_d   = sum_q;
                s_valid_d = 1'b1;
                cnt_d     = '0;
                acc_i_d   = '0;
                acc_q_d   = '0;
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
                cnt_d   = cnt_q + CNT_BITS'(1);
            end
        end
    end

    // S4 accumulator, block counter and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            out_i_q   <= '0;
            out_q_q   <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            s_valid_q <= 1'b0;
        end else begin
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            out_i_q   <= out_i_d;
            out_q_q   <= out_q_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            s_valid_q <= s_valid_d;
        end
    end

    // Registered result drives the output stream
    always_comb begin
        s_axis_tvalid = s_valid_q;
        i_out         = out_i_q;
        q_out         = out_q_q;
    end

endmodule

// File: tb/tb_cpx_mac.sv
// Scoreboard bench for cpx_mac: a plain-arithmetic model groups accepted pairs
// into blocks and queues expected sums; a monitor compares presented results.
module tb_cpx_mac;

    localparam int X_BITS   = 12;
    localparam int Y_BITS   = 12;
    localparam int CNT_BITS = 5;
    localparam int OUT_BITS = 29;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       m_axis_x_tvalid, m_axis_x_tready;
    logic                       m_axis_y_tvalid, m_axis_y_tready;
    logic signed [X_BITS-1:0]   xi, xq;
    logic signed [Y_BITS-1:0]   yi, yq;
    logic                       conj_en;
    logic [CNT_BITS-1:0]        acc_len;
    logic                       s_axis_tvalid, s_axis_tready;
    logic signed [OUT_BITS-1:0] i_out, q_out;

    always #5 clk = ~clk;

    cpx_mac #(
        .X_BITS      (X_BITS),
        .Y_BITS      (Y_BITS),
        .MAX_ACC_LEN (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_axis_x_tvalid (m_axis_x_tvalid),
        .m_axis_x_tready (m_axis_x_tready),
        .xi              (xi),
        .xq              (xq),
        .m_axis_y_tvalid (m_axis_y_tvalid),
        .m_axis_y_tready (m_axis_y_tready),
        .yi              (yi),
        .yq              (yq),
        .conj_en         (conj_en),
        .acc_len         (acc_len),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .i_out           (i_out),
        .q_out           (q_out)
    );

    typedef struct {
        longint i;
        longint q;
        int     acc_cyc;
        bit     chk_lat;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint m_i = 0, m_q = 0;
    int     m_cnt = 0, m_len = 1;
    bit     rand_ready = 1'b0;
    bit     ready_hold = 1'b1;
    bit     lat_ok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one complex product per accepted pair, block sums queued
    task automatic model_accept(input int a_i, a_q, b_i, b_q, input bit cj);
        longint pi, pq;
        if (m_cnt == 0) begin
            m_len = (acc_len == '0) ? 1 : int'(acc_len);
            m_i   = 0;
            m_q   = 0;
        end
        if (!cj) begin
            pi = longint'(a_i) * b_i - longint'(a_q) * b_q;
            pq = longint'(a_i) * b_q + longint'(a_q) * b_i;
        end else begin
            pi = longint'(a_i) * b_i + longint'(a_q) * b_q;
            pq = longint'(a_q) * b_i - longint'(a_i) * b_q;
        end
        m_i += pi;
        m_q += pq;
        m_cnt++;
        if (m_cnt == m_len) begin
            exp_t e;
            e.i       = m_i;
            e.q       = m_q;
            e.acc_cyc = cyc;
            e.chk_lat = lat_ok;
            exp_q.push_back(e);
            m_cnt = 0;
        end
    endtask

    task automatic send_pair(input int a_i, a_q, b_i, b_q, input bit cj);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        xi = X_BITS'(a_i);
        xq = X_BITS'(a_q);
        yi = Y_BITS'(b_i);
        yq = Y_BITS'(b_q);
        conj_en = cj;
        m_axis_x_tvalid = 1'b1;
        m_axis_y_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (m_axis_x_tready && m_axis_y_tready) begin
                model_accept(a_i, a_q, b_i, b_q, cj);
                done = 1'b1;
            end else begin
                n++;
                if (n >= 300) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout got=no_accept exp=accept");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic send_rand();
        send_pair(rnd_s(), rnd_s(), rnd_s(), rnd_s(), 1'($urandom_range(0, 1)));
    endtask

    // Idle cycles where at most one side is valid; nothing may be consumed
    task automatic rand_gap();
        int v;
        repeat ($urandom_range(0, 2)) begin
            v = int'($urandom_range(0, 2));
            m_axis_x_tvalid = (v == 1);
            m_axis_y_tvalid = (v == 2);
            xi = X_BITS'(rnd_s());
            yi = Y_BITS'(rnd_s());
            tick();
        end
    endtask

    task automatic idle(input int n);
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_ready = 1'b0;
        ready_hold = 1'b1;
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    // Downstream ready driver
    initial begin
        s_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_axis_tready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
        end
    end

    // Monitor: compare every presented result against the queue head
    bit   mon_prev_tv = 1'b0;
    bit   mon_prev_hs = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_tv = 1'b0;
            mon_prev_hs = 1'b0;
        end else begin
            if (s_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got i=%0d q=%0d exp=none", i_out, q_out);
                end else begin
                    mon_e = exp_q[0];
                    check("i_out", longint'(i_out), mon_e.i);
                    check("q_out", longint'(q_out), mon_e.q);
                    if (mon_e.chk_lat && (!mon_prev_tv || mon_prev_hs))
                        check("latency", longint'(cyc - mon_e.acc_cyc), 4);
                    if (!s_axis_tready) begin
                        check("bp_x_tready", longint'(m_axis_x_tready), 0);
                        check("bp_y_tready", longint'(m_axis_y_tready), 0);
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            mon_prev_tv = s_axis_tvalid;
            mon_prev_hs = s_axis_tvalid && s_axis_tready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0;
        conj_en = 1'b0;
        acc_len = CNT_BITS'(1);

        // Reset state, with both input valids raised
        #2;
        m_axis_x_tvalid = 1'b1;
        m_axis_y_tvalid = 1'b1;
        #1;
        check("rst_tvalid", longint'(s_axis_tvalid), 0);
        check("rst_i_out", longint'(i_out), 0);
        check("rst_q_out", longint'(q_out), 0);
        check("rst_x_tready", longint'(m_axis_x_tready), 0);
        check("rst_y_tready", longint'(m_axis_y_tready), 0);
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single products, normal and conjugate
        lat_ok = 1'b1;
        acc_len = CNT_BITS'(1);
        send_pair(3, 4, 1, -2, 1'b0);
        drain();
        send_pair(3, 4, 1, -2, 1'b1);
        drain();

        // Four-term conjugate block: power of x
        acc_len = CNT_BITS'(4);
        repeat (4) send_pair(100, -50, 100, -50, 1'b1);
        drain();

        // Full-length block at the most negative input
        acc_len = CNT_BITS'(16);
        repeat (16) send_pair(-2048, -2048, -2048, -2048, 1'b0);
        drain();
        lat_ok = 1'b0;

        // Backpressure while streaming, released later from a side thread
        acc_len = CNT_BITS'(2);
        ready_hold = 1'b0;
        fork
            begin
                repeat (25) @(posedge clk);
                ready_hold = 1'b1;
            end
        join_none
        repeat (8) send_rand();
        drain();

        // acc_len changed mid-block must not affect the running block
        acc_len = CNT_BITS'(4);
        send_rand();
        idle(6);
        acc_len = CNT_BITS'(2);
        repeat (3) send_rand();
        drain();

        // Lone x for 5 cycles
        m_axis_x_tvalid = 1'b1;
        m_axis_y_tvalid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("lone_x_tready", longint'(m_axis_x_tready), 0);
            check("lone_y_tready", longint'(m_axis_y_tready), 1);
            @(posedge clk);
            #1;
        end
        m_axis_x_tvalid = 1'b0;
        acc_len = CNT_BITS'(4);
        repeat (4) send_rand();
        drain();

        // Reset with a result pending and a partial block frozen in the pipe
        ready_hold = 1'b0;
        acc_len = CNT_BITS'(4);
        repeat (6) send_rand();
        idle(6);
        m_axis_x_tvalid = 1'b1;
        m_axis_y_tvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst2_tvalid", longint'(s_axis_tvalid), 0);
        check("rst2_x_tready", longint'(m_axis_x_tready), 0);
        check("rst2_y_tready", longint'(m_axis_y_tready), 0);
        exp_q.delete();
        m_cnt = 0;
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
        ready_hold = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        lat_ok = 1'b1;
        repeat (4) send_rand();
        drain();
        lat_ok = 1'b0;

        // Randomised streaming with gaps, random readies and varied lengths
        for (int seg = 0; seg < 6; seg++) begin
            int blocks;
            int len;
            len = (seg == 0) ? 0 : int'($urandom_range(1, 16));
            acc_len = CNT_BITS'(len);
            blocks = int'($urandom_range(1, 3));
            rand_ready = 1'b1;
            repeat (blocks * ((len == 0) ? 1 : len)) begin
                rand_gap();
                send_rand();
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
